// File: rtl/v_sram_mp_if.sv
// ---------------------------------------------------------------------------
// v_sram_mp_if
// Bus bundle for the multi-port vector SRAM model (v_sram_mp).
// Per-port fields are packed flat: port k occupies [k*W +: W] of each vector.
//
// Signals
//   we       NWR          per-port write enable
//   waddr    NWR*ADDR_W   write addresses
//   wdata    NWR*DATA_W   write data
//   re       NRD          per-port read enable
//   raddr    NRD*ADDR_W   read addresses
//   rdata    NRD*DATA_W   read data
//   rvalid   NRD          read data valid, one pulse per accepted read
//   wcollide 1            registered pulse: two or more enabled writes hit one address
//
// Modports
//   master   drives write/read requests, receives read data and collision flag
//   slave    the SRAM side
// ---------------------------------------------------------------------------
interface v_sram_mp_if #(
  parameter int DATA_W = 48,
  parameter int ADDR_W = 9,
  parameter int NRD    = 2,
  parameter int NWR    = 2
);

  logic [NWR-1:0]        we;
  logic [NWR*ADDR_W-1:0] waddr;
  logic [NWR*DATA_W-1:0] wdata;
  logic [NRD-1:0]        re;
  logic [NRD*ADDR_W-1:0] raddr;
  logic [NRD*DATA_W-1:0] rdata;
  logic [NRD-1:0]        rvalid;
  logic                  wcollide;

  modport master (
    output we, waddr, wdata, re, raddr,
    input  rdata, rvalid, wcollide
  );

  modport slave (
    input  we, waddr, wdata, re, raddr,
    output rdata, rvalid, wcollide
  );

endinterface

// File: rtl/v_sram_mp.sv
// ---------------------------------------------------------------------------
// v_sram_mp
// Parametrised multi-port SRAM model used as the vector datapath operand /
// result store. NWR write ports, NRD read ports, pipelined read latency RD_LAT.
//
// Ports
//   clock   rising-edge clock
//   reset   synchronous, active-high; clears read pipeline and collision flag,
//           leaves the array contents untouched
//   bus     v_sram_mp_if.slave (we/waddr/wdata, re/raddr, rdata/rvalid, wcollide)
//
// Behaviour summary
//   - Writes with an address >= DEPTH are dropped and never count as collisions.
//   - Several writers on one address: highest-index port wins, wcollide pulses.
//   - Reads sample raddr at the issue edge; result appears RD_LAT-1 edges later.
//     An out-of-range read completes with zero data. A slot without re keeps
//     the previous rdata and raises no rvalid.
//
// Optional feature
//   V_SRAM_WR_BYPASS_EN  defined  : write-first, a same-edge read of a written
//                                   address returns the winning new data.
//                        undefined: read-first, the old array word is returned.
// ---------------------------------------------------------------------------
module v_sram_mp #(
  parameter int DATA_W = 48,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int RD_LAT = 1
) (
  input logic        clock,
  input logic        reset,
  v_sram_mp_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  function automatic logic inRange(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < DEPTH_LIM;
  endfunction

  // NOTE: the storage array has no reset; only control state and the read
  // pipeline are cleared, so contents survive a reset pulse.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wAddr     [NWR];
  logic [DATA_W-1:0] wData     [NWR];
  logic [NWR-1:0]    wInRange;
  logic [ADDR_W-1:0] rAddr     [NRD];
  logic [NRD-1:0]    rInRange;

  for (genvar k = 0; k < NWR; k++) begin : gUnpackWr
    assign wAddr[k]    = bus.waddr[k*ADDR_W +: ADDR_W];
    assign wData[k]    = bus.wdata[k*DATA_W +: DATA_W];
    assign wInRange[k] = inRange(wAddr[k]);
  end

  for (genvar p = 0; p < NRD; p++) begin : gUnpackRd
    assign rAddr[p]    = bus.raddr[p*ADDR_W +: ADDR_W];
    assign rInRange[p] = inRange(rAddr[p]);
  end

  // -------------------------------------------------------------------------
  // Write ports. Iterating in ascending port order means the last scheduled
  // update to a shared address comes from the highest-index port, which wins.
  // -------------------------------------------------------------------------
  // NOTE: sequential state is always assigned with <= so every register sees
  // the pre-edge values of its sources regardless of statement order.
  always_ff @(posedge clock) begin : writePorts
    if (!reset) begin
      for (int k = 0; k < NWR; k++) begin
        if (bus.we[k] && wInRange[k]) begin
          mem[wAddr[k]] <= wData[k];
        end
      end
    end
  end

  // Collision detect over every pair of enabled, in-range writers.
  logic collide;
  logic collideQ;

  // NOTE: every combinational output gets a default before any condition so
  // no path leaves it unassigned (which would infer a latch).
  always_comb begin : collideDetect
    collide = 1'b0;
    for (int j = 0; j < NWR; j++) begin
      for (int k = j + 1; k < NWR; k++) begin
        if (bus.we[j] && bus.we[k] && wInRange[j] && wInRange[k] &&
            (wAddr[j] == wAddr[k])) begin
          collide = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin : collideReg
    if (reset) collideQ <= 1'b0;
    else       collideQ <= collide;
  end

  assign bus.wcollide = collideQ;

  // -------------------------------------------------------------------------
  // Array read at the issue edge. Out-of-range addresses return zero.
  // With bypass enabled, an in-flight write to the same address overrides
  // the stored word; ascending scan again lets the highest-index writer win.
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] readWord [NRD];

  always_comb begin : readMux
    for (int p = 0; p < NRD; p++) begin
      readWord[p] = '0;
      if (rInRange[p]) begin
        readWord[p] = mem[rAddr[p]];
`ifdef V_SRAM_WR_BYPASS_EN
        for (int k = 0; k < NWR; k++) begin
          if (bus.we[k] && wInRange[k] && (wAddr[k] == rAddr[p])) begin
            readWord[p] = wData[k];
          end
        end
`endif
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read pipeline: stage 0 captures the array word at the issue edge, later
  // stages are pure delay. Data in a stage only moves when its valid bit does,
  // so an idle slot leaves the output word unchanged.
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] stageData  [RD_LAT][NRD];
  logic [NRD-1:0]    stageValid [RD_LAT];

  always_ff @(posedge clock) begin : readPipe
    if (reset) begin
      for (int s = 0; s < RD_LAT; s++) begin
        stageValid[s] <= '0;
        for (int p = 0; p < NRD; p++) begin
          stageData[s][p] <= '0;
        end
      end
    end else begin
      stageValid[0] <= bus.re;
      for (int p = 0; p < NRD; p++) begin
        if (bus.re[p]) stageData[0][p] <= readWord[p];
      end
      for (int s = 1; s < RD_LAT; s++) begin
        stageValid[s] <= stageValid[s-1];
        for (int p = 0; p < NRD; p++) begin
          if (stageValid[s-1][p]) stageData[s][p] <= stageData[s-1][p];
        end
      end
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : gPackRd
    assign bus.rdata[p*DATA_W +: DATA_W] = stageData[RD_LAT-1][p];
  end

  assign bus.rvalid = stageValid[RD_LAT-1];

endmodule

// File: tb/tb_v_sram_mp.sv
// ---------------------------------------------------------------------------
// tb_v_sram_mp
// Self-checking bench for v_sram_mp. Three instances share clock and reset:
//   dut0  default configuration (48b x 512, 2R/2W, RD_LAT=1), table-driven
//   dut1  NRD=4, RD_LAT=3: streaming reads and mid-operation reset
//   dut2  DEPTH=500: out-of-range write/read handling
// Expected values follow V_SRAM_WR_BYPASS_EN when the macro is defined.
// ---------------------------------------------------------------------------
module tb_v_sram_mp;

`ifdef V_SRAM_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [47:0] A_WORD = 48'hA5A5_0000_1234;
  localparam logic [47:0] F_WORD = 48'hFFFF_0000_0001;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  v_sram_mp_if #(.DATA_W(48), .ADDR_W(9), .NRD(2), .NWR(2)) bus0 ();
  v_sram_mp_if #(.DATA_W(48), .ADDR_W(9), .NRD(4), .NWR(2)) bus1 ();
  v_sram_mp_if #(.DATA_W(48), .ADDR_W(9), .NRD(2), .NWR(2)) bus2 ();

  v_sram_mp dut0 (.clock(clock), .reset(reset), .bus(bus0));
  v_sram_mp #(.NRD(4), .RD_LAT(3)) dut1 (.clock(clock), .reset(reset), .bus(bus1));
  v_sram_mp #(.DEPTH(500)) dut2 (.clock(clock), .reset(reset), .bus(bus2));

  int passCnt  = 0;
  int totalCnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idleAll();
    bus0.we = '0; bus0.waddr = '0; bus0.wdata = '0; bus0.re = '0; bus0.raddr = '0;
    bus1.we = '0; bus1.waddr = '0; bus1.wdata = '0; bus1.re = '0; bus1.raddr = '0;
    bus2.we = '0; bus2.waddr = '0; bus2.wdata = '0; bus2.re = '0; bus2.raddr = '0;
  endtask

  function automatic logic [47:0] pat(input int a);
    return 48'hC0DE_0000_0000 | 48'(a);
  endfunction

  typedef struct {
    logic [1:0]  we;
    logic [8:0]  wa0, wa1;
    logic [47:0] wd0, wd1;
    logic [1:0]  re;
    logic [8:0]  ra0, ra1;
    logic [1:0]  expValid;
    logic [47:0] expD0, expD1;
    logic        expCol;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  initial begin
    // Outputs listed are those visible right after the edge that applies the row.
    vecs[0]  = '{2'b01, 9'h005, 9'h000, A_WORD, 48'h0, 2'b00, 9'h000, 9'h000, 2'b00, 48'h0, 48'h0, 1'b0};
    vecs[1]  = '{2'b00, 9'h000, 9'h000, 48'h0, 48'h0, 2'b01, 9'h005, 9'h000, 2'b01, A_WORD, 48'h0, 1'b0};
    vecs[2]  = '{2'b11, 9'h010, 9'h010, 48'h1, 48'h2, 2'b00, 9'h000, 9'h000, 2'b00, A_WORD, 48'h0, 1'b1};
    vecs[3]  = '{2'b00, 9'h000, 9'h000, 48'h0, 48'h0, 2'b11, 9'h010, 9'h005, 2'b11, 48'h2, A_WORD, 1'b0};
    vecs[4]  = '{2'b11, 9'h020, 9'h021, 48'h7, 48'h8, 2'b00, 9'h000, 9'h000, 2'b00, 48'h2, A_WORD, 1'b0};
    vecs[5]  = '{2'b01, 9'h020, 9'h000, 48'h9, 48'h0, 2'b01, 9'h020, 9'h000, 2'b01,
                 BYP ? 48'h9 : 48'h7, A_WORD, 1'b0};
    vecs[6]  = '{2'b00, 9'h000, 9'h000, 48'h0, 48'h0, 2'b11, 9'h020, 9'h020, 2'b11, 48'h9, 48'h9, 1'b0};
    vecs[7]  = '{2'b10, 9'h000, 9'h021, 48'h0, F_WORD, 2'b10, 9'h000, 9'h021, 2'b10,
                 48'h9, BYP ? F_WORD : 48'h8, 1'b0};
    vecs[8]  = '{2'b00, 9'h000, 9'h000, 48'h0, 48'h0, 2'b11, 9'h021, 9'h005, 2'b11, F_WORD, A_WORD, 1'b0};
    vecs[9]  = '{2'b11, 9'h1FF, 9'h1FF, 48'h3, 48'h4, 2'b00, 9'h000, 9'h000, 2'b00, F_WORD, A_WORD, 1'b1};
    vecs[10] = '{2'b00, 9'h000, 9'h000, 48'h0, 48'h0, 2'b01, 9'h1FF, 9'h000, 2'b01, 48'h4, A_WORD, 1'b0};
    vecs[11] = '{2'b11, 9'h020, 9'h020, 48'h5, 48'h6, 2'b01, 9'h020, 9'h000, 2'b01,
                 BYP ? 48'h6 : 48'h9, A_WORD, 1'b1};
    vecs[12] = '{2'b00, 9'h000, 9'h000, 48'h0, 48'h0, 2'b01, 9'h020, 9'h000, 2'b01, 48'h6, A_WORD, 1'b0};

    idleAll();
    reset = 1'b1;

    // ---- Reset with reads pending on every instance ----
    bus0.re = 2'b11; bus0.raddr = {9'h010, 9'h005};
    bus1.re = 4'hF;
    bus2.re = 2'b11;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("rst%0d d0 rvalid", i), 64'(bus0.rvalid), 64'h0);
      check($sformatf("rst%0d d0 rdata", i), 64'(bus0.rdata[47:0]), 64'h0);
      check($sformatf("rst%0d d0 rdata1", i), 64'(bus0.rdata[95:48]), 64'h0);
      check($sformatf("rst%0d d0 wcollide", i), 64'(bus0.wcollide), 64'h0);
      check($sformatf("rst%0d d1 rvalid", i), 64'(bus1.rvalid), 64'h0);
    end
    reset = 1'b0;
    idleAll();
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("post-rst%0d d0 rvalid", i), 64'(bus0.rvalid), 64'h0);
      check($sformatf("post-rst%0d d1 rvalid", i), 64'(bus1.rvalid), 64'h0);
    end

    // ---- Table-driven vectors on dut0 ----
    for (int i = 0; i < NVEC; i++) begin
      bus0.we    = vecs[i].we;
      bus0.waddr = {vecs[i].wa1, vecs[i].wa0};
      bus0.wdata = {vecs[i].wd1, vecs[i].wd0};
      bus0.re    = vecs[i].re;
      bus0.raddr = {vecs[i].ra1, vecs[i].ra0};
      tick();
      check($sformatf("vec%0d rvalid", i), 64'(bus0.rvalid), 64'(vecs[i].expValid));
      check($sformatf("vec%0d rdata0", i), 64'(bus0.rdata[47:0]), 64'(vecs[i].expD0));
      check($sformatf("vec%0d rdata1", i), 64'(bus0.rdata[95:48]), 64'(vecs[i].expD1));
      check($sformatf("vec%0d wcollide", i), 64'(bus0.wcollide), 64'(vecs[i].expCol));
    end
    idleAll();

    // ---- dut1: preload 0x40..0x4F, then stream 4 ports x 16 cycles ----
    for (int c = 0; c < 8; c++) begin
      bus1.we    = 2'b11;
      bus1.waddr = {9'(32'h40 + 2*c + 1), 9'(32'h40 + 2*c)};
      bus1.wdata = {pat(32'h40 + 2*c + 1), pat(32'h40 + 2*c)};
      tick();
    end
    idleAll();
    tick();
    for (int t = 0; t < 20; t++) begin
      bus1.re = (t < 16) ? 4'hF : 4'h0;
      for (int p = 0; p < 4; p++) begin
        bus1.raddr[p*9 +: 9] = 9'(32'h40 + ((t + p) & 15));
      end
      tick();
      check($sformatf("stream t%0d rvalid", t), 64'(bus1.rvalid),
            (t >= 2 && t <= 17) ? 64'hF : 64'h0);
      if (t >= 2 && t <= 17) begin
        for (int p = 0; p < 4; p++) begin
          check($sformatf("stream t%0d p%0d rdata", t, p), 64'(bus1.rdata[p*48 +: 48]),
                64'(pat(32'h40 + ((t - 2 + p) & 15))));
        end
      end
    end
    idleAll();

    // ---- dut1: reset while reads are in flight; write in reset cycle ignored ----
    bus1.re = 4'hF;
    bus1.raddr = {4{9'h040}};
    tick();
    tick();
    check("midrst issue rvalid", 64'(bus1.rvalid), 64'h0);
    bus1.re = 4'h0;
    reset = 1'b1;
    bus1.we = 2'b01; bus1.waddr = {9'h000, 9'h040}; bus1.wdata = {48'h0, 48'h0BAD};
    tick();
    check("midrst rvalid", 64'(bus1.rvalid), 64'h0);
    check("midrst rdata0", 64'(bus1.rdata[47:0]), 64'h0);
    reset = 1'b0;
    idleAll();
    tick();
    check("midrst+1 rvalid", 64'(bus1.rvalid), 64'h0);
    tick();
    check("midrst+2 rvalid", 64'(bus1.rvalid), 64'h0);
    bus1.re = 4'b0001; bus1.raddr = {27'h0, 9'h040};
    tick();
    bus1.re = 4'h0;
    tick();
    check("lat3 early rvalid", 64'(bus1.rvalid), 64'h0);
    tick();
    check("lat3 rvalid", 64'(bus1.rvalid), 64'h1);
    check("reset-write ignored", 64'(bus1.rdata[47:0]), 64'(pat(32'h40)));
    tick();
    check("lat3 pulse end", 64'(bus1.rvalid), 64'h0);
    check("lat3 rdata hold", 64'(bus1.rdata[47:0]), 64'(pat(32'h40)));

    // ---- dut2: DEPTH=500 boundary handling ----
    bus2.we = 2'b11; bus2.waddr = {9'h1FF, 9'h1F3}; bus2.wdata = {48'hEEEE, 48'h1234_5678_9ABC};
    tick();
    check("d500 mixed wcollide", 64'(bus2.wcollide), 64'h0);
    bus2.waddr = {9'h1FF, 9'h1FF};
    tick();
    check("d500 oor pair wcollide", 64'(bus2.wcollide), 64'h0);
    bus2.waddr = {9'h1F4, 9'h1F4};
    tick();
    check("d500 edge pair wcollide", 64'(bus2.wcollide), 64'h0);
    bus2.we = 2'b00;
    bus2.re = 2'b11; bus2.raddr = {9'h1F3, 9'h1FF};
    tick();
    check("d500 rvalid", 64'(bus2.rvalid), 64'h3);
    check("d500 oor rdata", 64'(bus2.rdata[47:0]), 64'h0);
    check("d500 intact rdata", 64'(bus2.rdata[95:48]), 64'h1234_5678_9ABC);
    bus2.re = 2'b01; bus2.raddr = {9'h000, 9'h1F4};
    tick();
    check("d500 edge rvalid", 64'(bus2.rvalid), 64'h1);
    check("d500 edge rdata", 64'(bus2.rdata[47:0]), 64'h0);
    check("d500 hold rdata1", 64'(bus2.rdata[95:48]), 64'h1234_5678_9ABC);
    bus2.re = 2'b00;
    bus2.we = 2'b11; bus2.waddr = {9'h1F3, 9'h1F3}; bus2.wdata = {48'h2, 48'h1};
    tick();
    check("d500 in-range wcollide", 64'(bus2.wcollide), 64'h1);
    idleAll();
    tick();
    check("d500 wcollide pulse end", 64'(bus2.wcollide), 64'h0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
